// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: control FSM running n_iter multiply iterations per start, with a
// mul_rdy watchdog and busy/done/sticky-error status; state advances on falling clk.
module mul_seq_ctrl #(
    parameter int CNT_W   = 8,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_iter,
    input  logic             ready,
    input  logic             mul_rdy,
    output logic             store,
    output logic             mul_start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_idx
);
    localparam logic [4:0] S_IDLE  = 5'b00001;
    localparam logic [4:0] S_START = 5'b00010;
    localparam logic [4:0] S_MUL   = 5'b00100;
    localparam logic [4:0] S_DONE  = 5'b01000;
    localparam logic [4:0] S_ERR   = 5'b10000;
    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    logic [4:0]       state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d, idx_q, idx_d;
    logic [TO_W-1:0]  wdog_q, wdog_d;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        wdog_d  = wdog_q;
        if (ready) begin
            state_d = S_IDLE;
        end else if (start) begin
            rem_d   = n_iter;
            idx_d   = '0;
            wdog_d  = '0;
            state_d = (n_iter == '0) ? S_DONE : S_START;
        end else begin
            case (state_q)
                S_START: begin
                    wdog_d  = '0;
                    state_d = S_MUL;
                end
                S_MUL: begin
                    if (mul_rdy) begin
                        if (rem_q == CNT_W'(1)) begin
                            state_d = S_DONE;
                        end else begin
                            rem_d   = rem_q - CNT_W'(1);
                            idx_d   = idx_q + CNT_W'(1);
                            state_d = S_START;
                        end
                    end else begin
                        wdog_d  = wdog_q + TO_W'(1);
                        state_d = (wdog_q == WD_LAST) ? S_ERR : S_MUL;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            wdog_q  <= wdog_d;
        end
    end

    // combinational strobes are gated by rst so they drop with it asynchronously
    assign store     = !rst && !ready && (start || (state_q == S_MUL && mul_rdy));
    assign mul_start = !rst && !ready && !start && state_q == S_START;
    assign busy      = state_q == S_START || state_q == S_MUL;
    assign done      = state_q == S_DONE;
    assign err       = state_q == S_ERR;
    assign iter_idx  = idx_q;
endmodule
